// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared FSM state type and default word width for piso_tx
package piso_tx_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter with zero-gap back-to-back words and a word counter
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             pin_valid,
  output logic             pin_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy,
  output logic [7:0]       word_cnt
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_sout;
  logic             r_valid;
  logic             r_last;
  logic [7:0]       r_word_cnt;
  logic [WIDTH-1:0] w_next;
  logic             w_accept;
  assign w_next     = LSB_FIRST ? r_shift >> 1 : r_shift << 1;
  assign pin_ready  = (r_state == IDLE) | r_last;
  assign w_accept   = pin_valid & pin_ready;
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign sout_last  = r_last;
  assign busy       = r_valid;
  assign word_cnt   = r_word_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sout     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (r_last) r_word_cnt <= r_word_cnt + 8'd1;
      if (w_accept) begin
        r_state <= SHIFT;
        r_shift <= pin;
        r_cnt   <= CW'(WIDTH - 1);
        r_sout  <= LSB_FIRST ? pin[0] : pin[WIDTH-1];
        r_valid <= 1'b1;
        r_last  <= 1'b0;
      end else if (r_last) begin
        r_state <= IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
        r_sout  <= 1'b0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_shift <= w_next;
        r_cnt   <= r_cnt - 1'b1;
        r_sout  <= LSB_FIRST ? w_next[0] : w_next[WIDTH-1];
        r_last  <= (r_cnt == CW'(1));
      end
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx in MSB-first and LSB-first builds
module tb_piso_tx;
  typedef struct packed {logic b; logic last;} exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pin = '0;
  logic       pin_valid = 1'b0;
  logic       pin_ready, sout, sout_valid, sout_last, busy;
  logic [7:0] word_cnt;
  logic       pin_ready_l, sout_l, sout_valid_l, sout_last_l, busy_l;
  logic [7:0] word_cnt_l;
  exp_t       q_m[$];
  exp_t       q_l[$];
  logic [7:0] exp_wc = '0;
  int         n_chk = 0;
  int         n_err = 0;
  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .pin(pin), .pin_valid(pin_valid), .pin_ready(pin_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .busy(busy), .word_cnt(word_cnt)
  );
  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .pin(pin), .pin_valid(pin_valid), .pin_ready(pin_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .sout_last(sout_last_l), .busy(busy_l), .word_cnt(word_cnt_l)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      logic exp_ready;
      exp_ready = (q_m.size() == 0) || q_m[0].last;
      chk("ready", pin_ready, exp_ready);
      chk("ready_l", pin_ready_l, exp_ready);
      chk("valid", sout_valid, q_m.size() != 0);
      chk("busy", busy, q_m.size() != 0);
      chk("valid_l", sout_valid_l, q_l.size() != 0);
      chk("busy_l", busy_l, q_l.size() != 0);
      chk("word_cnt", word_cnt, exp_wc);
      chk("word_cnt_l", word_cnt_l, exp_wc);
      if (q_l.size() != 0) begin
        e = q_l.pop_front();
        chk("bit_l", sout_l, e.b);
        chk("last_l", sout_last_l, e.last);
      end else chk("idle_out_l", {sout_l, sout_last_l}, 0);
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("bit", sout, e.b);
        chk("last", sout_last, e.last);
        if (e.last) exp_wc = exp_wc + 8'd1;
      end else chk("idle_out", {sout, sout_last}, 0);
    end
  end
  task automatic send(input logic [3:0] w, input bit hold);
    bit ok = 0;
    pin = w;
    pin_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pin_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      pin_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      q_m.push_back('{w[3-i], i == 3});
      q_l.push_back('{w[i], i == 3});
    end
    #1;
    if (!hold) pin_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q_m.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q_m.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    q_m.delete();
    q_l.delete();
    exp_wc = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    pin = 4'hf;
    pin_valid = 1'b1;
    do_reset(3);
    pin_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", pin_ready, 1);
    chk("valid_after_rst", sout_valid, 0);
    @(posedge clk);
    #1;
    send(4'b1000, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q_m.delete();
    q_l.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", sout_valid, 0);
    chk("midrst_wc", word_cnt, 0);
    chk("midrst_ready", pin_ready, 1);
    @(posedge clk);
    #1;
    send(4'b1010, 0);
    drain();
    chk("single_wc", word_cnt, 1);
    send(4'b0011, 1);
    send(4'b1100, 0);
    drain();
    send(4'b0001, 0);
    drain();
    send(4'b1001, 0);
    @(posedge clk);
    #1;
    send(4'b1111, 0);
    drain();
    chk("mid_wc", word_cnt, 6);
    do_reset(1);
    for (int i = 0; i < 256; i++) send(4'($urandom_range(0, 15)), i != 255);
    drain();
    chk("wrap_wc", word_cnt, 0);
    chk("wrap_wc_l", word_cnt_l, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..16.
REQ-002 Parameter LSB_FIRST, default 0: 0 = serialize MSB first, 1 = LSB first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pin  input  WIDTH  parallel word to transmit; sampled only on an accept cycle.
REQ-006 pin_valid  input  1  producer presents a word on pin.
REQ-007 pin_ready  output  1  block can take a word this cycle; combinational from registered state only, never from pin_valid.
REQ-008 sout  output  1  registered serial data bit.
REQ-009 sout_valid  output  1  registered; sout carries a payload bit this cycle.
REQ-010 sout_last  output  1  registered; marks the final bit of the current word.
REQ-011 busy  output  1  registered; high while a word is being shifted out.
REQ-012 word_cnt  output  8  registered count of completed words, wraps 255 -> 0.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 An accept SHALL occur on any rising edge where pin_valid = 1 and pin_ready = 1.
REQ-015 In IDLE, pin_ready SHALL be 1.
REQ-016 In SHIFT, pin_ready SHALL be 1 only while sout_last = 1, which enables back-to-back words; otherwise it SHALL be 0.
REQ-017 On accept, pin SHALL be loaded into the shift register, the bit counter set to WIDTH-1, and the state set to SHIFT.
REQ-018 Latency: the first bit SHALL appear on sout, with sout_valid = 1, in the cycle immediately after the accepting edge.
REQ-019 Each word SHALL occupy exactly WIDTH consecutive sout_valid cycles, in the bit order selected by LSB_FIRST.
REQ-020 The bit counter SHALL decrement once per SHIFT cycle, and sout_last SHALL be 1 exactly when the counter reads 0.
REQ-021 On the sout_last cycle:
- with no accept, the next state SHALL be IDLE;
- with an accept, the next state SHALL stay SHIFT and the new word's first bit SHALL follow with zero gap.
REQ-022 word_cnt SHALL increment by 1 on the edge that ends each sout_last cycle, wrapping modulo 256.
REQ-023 In IDLE, sout, sout_valid, sout_last and busy SHALL all be 0.
REQ-024 busy SHALL equal sout_valid.
REQ-025 pin changes or pin_valid toggles while pin_ready = 0 SHALL have no effect on the word in flight.
REQ-026 pin_valid held high continuously SHALL yield a continuous serial stream at 1 word per WIDTH cycles.

Reset
REQ-027 While rst = 1 at a rising edge, the following SHALL be cleared at that edge, regardless of state:
- state to IDLE;
- shift register, bit counter and word_cnt to 0;
- sout, sout_valid, sout_last and busy to 0.
REQ-028 Reset asserted mid-word SHALL abandon the word, with no partial-word completion and no word_cnt increment.
REQ-029 pin_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-030 An accept with rst = 1 on the same edge SHALL be ignored, because reset wins.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, SHIFT) and the constant for the default WIDTH of 4.
REQ-032 The block SHALL be one flat module with no sub-modules; the bit counter and shift register are inline.

Verification
REQ-033 Single word, WIDTH=4, MSB first: reset for 3 cycles, then one accept of pin=4'b1010 -> sout reads 1,0,1,0 over the next 4 cycles, sout_last only on the 4th, word_cnt goes 0 -> 1, then IDLE.
REQ-034 Back-to-back: words 4'b0011 then 4'b1100, pin_valid held high -> 8 contiguous valid bits 0,0,1,1,1,1,0,0; pin_ready high only on cycles 0 and 4.
REQ-035 LSB_FIRST=1 with pin=4'b0001 -> sout reads 1,0,0,0.
REQ-036 Ignore mid-word: pin changes to 4'b1111 with pin_valid=1 during bits 2-3 of word 4'b1001 -> output stays 1,0,0,1, and the new word is accepted only at sout_last.
REQ-037 Reset mid-word: rst asserted after the 2nd bit of 4'b1000 -> next cycle sout_valid=0, word_cnt unchanged, pin_ready=1.
REQ-038 Wrap-around: 256 consecutive words -> word_cnt returns to 0 with no gap in the stream.
